dmux_stream_1xn: RTL and testbench
==================================

// Module: dmux_stream_1xn
// PURPOSE
//  Registered 1-to-N stream demultiplexer with per-channel valid/ready handshake. Successor to the
//  combinational 1xN demux: one input word of WIDTH bits is steered by Sel into one of N output
//  channels. Each channel has its own one-entry output register, so a stalled consumer does not
//  block traffic to other channels. Sits between a single producer and N independent consumers.
// PARAMETERS
//  N      8   number of output channels, 2..64, not required to be a power of two
//  WIDTH  8   data width per word, >=1
//  SEL_W  $clog2(N)  Sel width (localparam, derived)
// PORTS
//  clk        in   1         clock; all state updates on rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         input word present
//  in_ready   out  1         demux accepts input this cycle
//  D          in   WIDTH     input data
//  Sel        in   SEL_W     destination channel
//  Y          out  N*WIDTH   channel data, packed; channel k = Y[k*WIDTH +: WIDTH]
//  Y_valid    out  N         channel k holds a word
//  Y_ready    in   N         consumer k accepts word this cycle
//  sel_err    out  1         one-cycle pulse: a word with Sel>=N was accepted and dropped
// BEHAVIOUR
//  - Reset: Y_valid=0, Y=0, sel_err=0; any held word is discarded. Reset dominates all other inputs.
//  - Channel k transfer out: Y_valid[k] & Y_ready[k] at an edge.
//  - in_ready = (Sel>=N) | ~Y_valid[Sel] | Y_ready[Sel]; combinational from Sel, Y_valid, Y_ready.
//  - Input transfer: in_valid & in_ready. Word written to channel Sel register; Y_valid[Sel]=1 next
//    cycle. Latency D->Y: exactly 1 cycle.
//  - Simultaneous drain and fill of same channel: old word leaves, new word loaded, Y_valid stays 1.
//  - Channel drained with no fill: Y_valid[k]<=0; Y[k] data holds last value (don't-care).
//  - Y[k] and Y_valid[k] stable while Y_valid[k]&~Y_ready[k] (no change under backpressure).
//  - Sel>=N (non-power-of-two N): word accepted, dropped, sel_err=1 next cycle, no channel changes.
//  - in_valid=0: no register changes except drains; in_ready value ignored by producer.
//  - Per-channel order preserved; no ordering guarantee across channels (separate consumers).
//  - Throughput: 1 word/cycle as long as target channel is empty or draining.
// CONFIGURATION
//  DMUX_STREAM_CNT_EN defined: adds output cnt[N*16-1:0]; channel k's 16-bit counter increments on
//   each channel-k output transfer, saturates at 16'hFFFF, clears on rst. Also adds input
//   cnt_clr (1 bit): synchronous clear of all counters, takes priority over increment.
//  Not defined: ports cnt and cnt_clr absent, no counter logic; all other behaviour identical.
// STRUCTURE
//  - Shared package dmux_pkg: SEL_W computation function, CNT_W=16 constant, CNT_MAX constant.
//  - Sub-module dmux_chan_reg (WIDTH): one-entry valid/ready pipe register with load, drain,
//    simultaneous load+drain; instantiated N times via generate loop.
//  - Top: Sel decode to one-hot load vector, in_ready mux, sel_err register, optional counters.
// TESTING (N=8, WIDTH=8 unless stated)
//  1 Reset: assert rst 2 cycles mid-traffic with Y_valid=8'h05 -> Y_valid=0, sel_err=0 next cycle.
//  2 Sweep: Y_ready=all 1, D=8'hA0+k, Sel=k for k=0..7 back-to-back -> Y_valid[k] one cycle after
//    each, channel k data=8'hA0+k, in_ready stays 1, 8 words in 8 cycles.
//  3 Backpressure: Y_ready[3]=0, send D=8'h11 then 8'h22 to Sel=3 -> first held stable, in_ready=0
//    on second; release Y_ready[3] -> 8'h11 out, 8'h22 loaded same edge, Y_valid[3] stays 1.
//  4 Isolation: channel 3 stalled full, send D=8'h55 to Sel=6 -> accepted, Y_valid[6]=1 next cycle.
//  5 Out of range: N=6, Sel=7, D=8'hFF -> in_ready=1, sel_err pulses 1 cycle, Y_valid unchanged.
//  6 With DMUX_STREAM_CNT_EN: 3 transfers on channel 2 -> cnt[2]=3; preload to 16'hFFFE, 3 more ->
//    16'hFFFF; cnt_clr=1 one cycle -> all counters 0.

Source files
------------

// File: rtl/dmux_pkg.sv
// Shared constants and helpers for the registered 1xN stream demultiplexer.
package dmux_pkg;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  // Select width for an N-way demux; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmux_stream_1xn_if.sv
// Stream bundle for dmux_stream_1xn: one producer side, N packed consumer channels.
interface dmux_stream_1xn_if #(
  parameter int N     = 8,
  parameter int WIDTH = 8
);
  import dmux_pkg::*;

  localparam int SEL_W = sel_width(N);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     D;
  logic [SEL_W-1:0]     Sel;
  logic [N*WIDTH-1:0]   Y;
  logic [N-1:0]         Y_valid;
  logic [N-1:0]         Y_ready;
  logic                 sel_err;

  modport master (
    output in_valid, D, Sel, Y_ready,
    input  in_ready, Y, Y_valid, sel_err
  );

  modport slave (
    input  in_valid, D, Sel, Y_ready,
    output in_ready, Y, Y_valid, sel_err
  );

endinterface

// File: rtl/dmux_chan_reg.sv
// One-entry valid/ready output register; supports load, drain and load+drain in the same cycle.
module dmux_chan_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // The parent only asserts i_load when this slot is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/dmux_stream_1xn.sv
// Registered 1-to-N stream demux with independent per-channel output registers.
// Optional per-channel transfer counters are enabled by defining DMUX_STREAM_CNT_EN.
module dmux_stream_1xn
  import dmux_pkg::*;
#(
  parameter int N     = 8,
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  dmux_stream_1xn_if.slave     bus
`ifdef DMUX_STREAM_CNT_EN
  ,
  output logic [N*CNT_W-1:0]   cnt,
  input  logic                 cnt_clr
`endif
);

  localparam int SEL_W = sel_width(N);

  logic [N-1:0]       w_sel_onehot;
  logic [N-1:0]       w_load;
  logic [N-1:0]       w_chan_valid;
  logic [N*WIDTH-1:0] w_chan_data;
  logic               w_sel_oor;
  logic               w_tgt_blocked;
  logic               w_accept;
  logic               r_sel_err;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign w_sel_onehot[gi] = (bus.Sel == SEL_W'(gi));

      dmux_chan_reg #(.WIDTH(WIDTH)) u_chan (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load[gi]),
        .i_data  (bus.D),
        .i_ready (bus.Y_ready[gi]),
        .o_valid (w_chan_valid[gi]),
        .o_data  (w_chan_data[gi*WIDTH +: WIDTH])
      );
    end
  endgenerate

  // An out-of-range Sel decodes to no channel, so it is never blocked and is simply dropped.
  assign w_sel_oor     = ~|w_sel_onehot;
  assign w_tgt_blocked = |(w_sel_onehot & w_chan_valid & ~bus.Y_ready);
  assign w_accept      = bus.in_valid & ~w_tgt_blocked;
  assign w_load        = w_sel_onehot & {N{w_accept}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel_err <= 1'b0;
    end else begin
      r_sel_err <= w_accept & w_sel_oor;
    end
  end

  assign bus.in_ready = ~w_tgt_blocked;
  assign bus.Y        = w_chan_data;
  assign bus.Y_valid  = w_chan_valid;
  assign bus.sel_err  = r_sel_err;

`ifdef DMUX_STREAM_CNT_EN
  generate
    for (gi = 0; gi < N; gi++) begin : g_cnt
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
          r_cnt <= '0;
        end else if (w_chan_valid[gi] && bus.Y_ready[gi] && (r_cnt != CNT_MAX)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign cnt[gi*CNT_W +: CNT_W] = r_cnt;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_dmux_stream_1xn.sv
// Directed self-checking bench for dmux_stream_1xn (N=8 instance plus an N=6 instance for Sel>=N).
module tb_dmux_stream_1xn;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  dmux_stream_1xn_if #(.N(8), .WIDTH(8)) b8 ();
  dmux_stream_1xn_if #(.N(6), .WIDTH(8)) b6 ();

`ifdef DMUX_STREAM_CNT_EN
  logic [8*16-1:0] cnt8;
  logic [6*16-1:0] cnt6;
  logic            cnt_clr = 1'b0;
`endif

  dmux_stream_1xn #(.N(8), .WIDTH(8)) dut8 (
    .clk     (clk),
    .rst     (rst),
    .bus     (b8)
`ifdef DMUX_STREAM_CNT_EN
    ,
    .cnt     (cnt8),
    .cnt_clr (cnt_clr)
`endif
  );

  dmux_stream_1xn #(.N(6), .WIDTH(8)) dut6 (
    .clk     (clk),
    .rst     (rst),
    .bus     (b6)
`ifdef DMUX_STREAM_CNT_EN
    ,
    .cnt     (cnt6),
    .cnt_clr (cnt_clr)
`endif
  );

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    b8.Y_ready = 8'h00; b8.in_valid = 1'b1; b8.Sel = 3'd0; b8.D = 8'h33;
    @(negedge clk);
    b8.Sel = 3'd2; b8.D = 8'h44;
    @(negedge clk);
    b8.in_valid = 1'b0;
    n_checks++;
    if (b8.Y_valid !== 8'h05) begin
      n_errors++; $display("FAIL reset_pre_valid: got %h expected %h", b8.Y_valid, 8'h05);
    end
    $display("reset: traffic Y_valid=%h, asserting rst with a pending load", b8.Y_valid);
    rst = 1'b1; b8.in_valid = 1'b1; b8.Sel = 3'd5; b8.D = 8'h99;
    @(negedge clk);
    n_checks++;
    if (b8.Y_valid !== 8'h00 || b8.sel_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_first_cycle: got valid=%h err=%b expected 00/0", b8.Y_valid, b8.sel_err);
    end
    @(negedge clk);
    rst = 1'b0; b8.in_valid = 1'b0;
    n_checks++;
    if (b8.Y_valid !== 8'h00 || b8.Y !== 64'h0) begin
      n_errors++; $display("FAIL reset_state: got valid=%h Y=%h expected 00/0", b8.Y_valid, b8.Y);
    end
    n_checks++;
    if (b6.Y_valid !== 6'h00 || b6.sel_err !== 1'b0) begin
      n_errors++; $display("FAIL reset_n6: got valid=%h err=%b expected 00/0", b6.Y_valid, b6.sel_err);
    end
  endtask

  task automatic test_sweep();
    int accepted = 0;
    b8.Y_ready = 8'hFF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k > 0) begin
        n_checks++;
        if (b8.Y_valid !== (8'h01 << (k - 1)) || b8.Y[(k-1)*8 +: 8] !== (8'hA0 + 8'(k - 1))) begin
          n_errors++;
          $display("FAIL sweep_ch%0d: got valid=%h data=%h expected %h/%h", k - 1, b8.Y_valid,
                   b8.Y[(k-1)*8 +: 8], 8'h01 << (k - 1), 8'hA0 + 8'(k - 1));
        end
      end
      b8.in_valid = 1'b1; b8.Sel = 3'(k); b8.D = 8'hA0 + 8'(k);
      #1;
      n_checks++;
      if (b8.in_ready !== 1'b1) begin
        n_errors++; $display("FAIL sweep_ready_%0d: got %b expected 1", k, b8.in_ready);
      end else begin
        accepted++;
      end
      $display("sweep: send D=%h Sel=%0d", b8.D, k);
    end
    @(negedge clk);
    b8.in_valid = 1'b0;
    n_checks++;
    if (b8.Y_valid !== 8'h80 || b8.Y[7*8 +: 8] !== 8'hA7 || accepted != 8) begin
      n_errors++;
      $display("FAIL sweep_last: got valid=%h data=%h acc=%0d expected 80/a7/8", b8.Y_valid, b8.Y[56 +: 8], accepted);
    end
    @(negedge clk);
    n_checks++;
    if (b8.Y_valid !== 8'h00 || b8.sel_err !== 1'b0) begin
      n_errors++; $display("FAIL sweep_drained: got valid=%h err=%b expected 00/0", b8.Y_valid, b8.sel_err);
    end
  endtask

  task automatic test_backpressure();
    b8.Y_ready = 8'hF7;
    b8.in_valid = 1'b1; b8.Sel = 3'd3; b8.D = 8'h11;
    #1;
    n_checks++;
    if (b8.in_ready !== 1'b1) begin
      n_errors++; $display("FAIL bp_first_ready: got %b expected 1", b8.in_ready);
    end
    $display("backpressure: send D=11 Sel=3");
    @(negedge clk);
    b8.D = 8'h22;
    #1;
    n_checks++;
    if (b8.in_ready !== 1'b0) begin
      n_errors++; $display("FAIL bp_second_ready: got %b expected 0", b8.in_ready);
    end
    @(negedge clk);
    n_checks++;
    if (b8.Y_valid[3] !== 1'b1 || b8.Y[24 +: 8] !== 8'h11) begin
      n_errors++; $display("FAIL bp_hold: got valid=%b data=%h expected 1/11", b8.Y_valid[3], b8.Y[24 +: 8]);
    end
    b8.Y_ready = 8'hFF;
    #1;
    n_checks++;
    if (b8.in_ready !== 1'b1) begin
      n_errors++; $display("FAIL bp_release_ready: got %b expected 1", b8.in_ready);
    end
    $display("backpressure: release Y_ready[3], D=22 Sel=3");
    @(negedge clk);
    b8.in_valid = 1'b0; b8.Y_ready = 8'hF7;
    n_checks++;
    if (b8.Y_valid[3] !== 1'b1 || b8.Y[24 +: 8] !== 8'h22) begin
      n_errors++; $display("FAIL bp_swap: got valid=%b data=%h expected 1/22", b8.Y_valid[3], b8.Y[24 +: 8]);
    end
  endtask

  task automatic test_isolation();
    @(negedge clk);
    b8.in_valid = 1'b1; b8.Sel = 3'd6; b8.D = 8'h55;
    #1;
    n_checks++;
    if (b8.in_ready !== 1'b1) begin
      n_errors++; $display("FAIL iso_ready: got %b expected 1", b8.in_ready);
    end
    $display("isolation: send D=55 Sel=6 with ch3 stalled");
    @(negedge clk);
    b8.in_valid = 1'b0;
    n_checks++;
    if (b8.Y_valid !== 8'h48 || b8.Y[48 +: 8] !== 8'h55 || b8.Y[24 +: 8] !== 8'h22) begin
      n_errors++;
      $display("FAIL iso_state: got valid=%h ch6=%h ch3=%h expected 48/55/22", b8.Y_valid, b8.Y[48 +: 8], b8.Y[24 +: 8]);
    end
    b8.Y_ready = 8'hFF;
    @(negedge clk);
    n_checks++;
    if (b8.Y_valid !== 8'h00) begin
      n_errors++; $display("FAIL iso_drain: got %h expected 00", b8.Y_valid);
    end
  endtask

  task automatic test_out_of_range();
    b6.Y_ready = 6'h00; b6.in_valid = 1'b1; b6.Sel = 3'd1; b6.D = 8'h12;
    @(negedge clk);
    b6.Sel = 3'd7; b6.D = 8'hFF;
    #1;
    n_checks++;
    if (b6.in_ready !== 1'b1 || b6.sel_err !== 1'b0) begin
      n_errors++; $display("FAIL oor_ready: got rdy=%b err=%b expected 1/0", b6.in_ready, b6.sel_err);
    end
    $display("out_of_range: send D=ff Sel=7 on N=6");
    @(negedge clk);
    b6.Sel = 3'd6; b6.D = 8'hEE;
    n_checks++;
    if (b6.sel_err !== 1'b1 || b6.Y_valid !== 6'h02 || b6.Y[8 +: 8] !== 8'h12) begin
      n_errors++;
      $display("FAIL oor_pulse7: got err=%b valid=%h ch1=%h expected 1/02/12", b6.sel_err, b6.Y_valid, b6.Y[8 +: 8]);
    end
    $display("out_of_range: send D=ee Sel=6 on N=6");
    @(negedge clk);
    b6.in_valid = 1'b0;
    n_checks++;
    if (b6.sel_err !== 1'b1 || b6.Y_valid !== 6'h02) begin
      n_errors++; $display("FAIL oor_pulse6: got err=%b valid=%h expected 1/02", b6.sel_err, b6.Y_valid);
    end
    @(negedge clk);
    n_checks++;
    if (b6.sel_err !== 1'b0 || b6.Y_valid !== 6'h02) begin
      n_errors++; $display("FAIL oor_end: got err=%b valid=%h expected 0/02", b6.sel_err, b6.Y_valid);
    end
    b6.Y_ready = 6'h3F;
    @(negedge clk);
  endtask

`ifdef DMUX_STREAM_CNT_EN
  task automatic test_counters();
    b8.Y_ready = 8'hFF; b8.in_valid = 1'b0;
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    n_checks++;
    if (cnt8 !== '0) begin
      n_errors++; $display("FAIL cnt_initial_clear: got %h expected 0", cnt8);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b8.in_valid = 1'b1; b8.Sel = 3'd2; b8.D = 8'(i);
      $display("counters: send D=%h Sel=2", b8.D);
    end
    @(negedge clk);
    b8.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cnt8[2*16 +: 16] !== 16'd3 || cnt8[0 +: 32] !== 32'h0 || cnt8[48 +: 80] !== 80'h0) begin
      n_errors++; $display("FAIL cnt_three: got %h expected ch2=0003 others 0", cnt8);
    end
    for (int i = 0; i < 65531; i++) begin
      b8.in_valid = 1'b1; b8.Sel = 3'd2; b8.D = 8'(i);
      @(negedge clk);
    end
    b8.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cnt8[2*16 +: 16] !== 16'hFFFE) begin
      n_errors++; $display("FAIL cnt_fffe: got %h expected fffe", cnt8[2*16 +: 16]);
    end
    for (int i = 0; i < 3; i++) begin
      b8.in_valid = 1'b1; b8.Sel = 3'd2; b8.D = 8'(i);
      @(negedge clk);
    end
    b8.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cnt8[2*16 +: 16] !== 16'hFFFF) begin
      n_errors++; $display("FAIL cnt_saturate: got %h expected ffff", cnt8[2*16 +: 16]);
    end
    b8.in_valid = 1'b1; b8.Sel = 3'd2;
    @(negedge clk);
    b8.in_valid = 1'b0; cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    n_checks++;
    if (cnt8 !== '0 || cnt6 !== '0) begin
      n_errors++; $display("FAIL cnt_clr: got %h / %h expected 0", cnt8, cnt6);
    end
  endtask
`endif

  initial begin
    b8.in_valid = 1'b0; b8.D = '0; b8.Sel = '0; b8.Y_ready = '0;
    b6.in_valid = 1'b0; b6.D = '0; b6.Sel = '0; b6.Y_ready = '0;
    test_reset();
    test_sweep();
    test_backpressure();
    test_isolation();
    test_out_of_range();
`ifdef DMUX_STREAM_CNT_EN
    test_counters();
`endif
    n_checks++;
    if (b8.sel_err !== 1'b0) begin
      n_errors++; $display("FAIL n8_sel_err: got %b expected 0", b8.sel_err);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
